cm0_mtx_in_hold: RTL and testbench

- AHB-Lite input stage of the bus matrix. It sits between one master-side slave interface and the output-port arbitration/mux stage.
- When the output port is not granted or is stalled, it registers the address-phase controls of a new transfer. It stalls the master via HREADYOUTS until the output stage accepts the transfer.
- It generates the per-port request consumed by the output arbiter and forwards the data-phase response back to the master.

---
 rtl/cm0_mtx_in_hold.sv | 183 ++++++++++++++++++
 tb/tb_cm0_mtx_in_hold.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cm0_mtx_in_hold.sv
// Bus-matrix AHB-Lite input stage: holds address-phase controls while the output port is busy.
// Optional two-cycle ERROR response for unmapped addresses when CM0_MTX_IN_ERR_EN is defined.
module cm0_mtx_in_hold #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  input  logic                  sel_none,
  output logic                  req_port,
  input  logic                  grant,
  input  logic                  HREADYM,
  input  logic                  HRESPM,
  output logic                  HSELM,
  output logic [ADDR_WIDTH-1:0] HADDRM,
  output logic [1:0]            HTRANSM,
  output logic                  HWRITEM,
  output logic [2:0]            HSIZEM,
  output logic [2:0]            HBURSTM,
  output logic [3:0]            HPROTM,
  output logic                  HMASTLOCKM
);

  logic                  live_valid, load_en, accept;
  logic                  hold_valid_q, hold_valid_d;
  logic                  data_phase_q, data_phase_d;
  logic                  seen_q, seen_d;
  logic [ADDR_WIDTH-1:0] haddr_q;
  logic [1:0]            htrans_q;
  logic                  hwrite_q, hmastlock_q;
  logic [2:0]            hsize_q, hburst_q;
  logic [3:0]            hprot_q;
  logic                  err_ready, err_resp;

  assign live_valid = HSELS & HREADYS & HTRANSS[1] & ~sel_none;
  assign load_en    = HSELS & HREADYS;
  assign accept     = grant & HREADYM & (hold_valid_q | live_valid);

  always_comb begin
    hold_valid_d = hold_valid_q;
    if (hold_valid_q) begin
      if (grant & HREADYM) hold_valid_d = 1'b0;
    end else if (live_valid & ~(grant & HREADYM)) begin
      hold_valid_d = 1'b1;
    end

    data_phase_d = data_phase_q;
    if (accept)       data_phase_d = 1'b1;
    else if (HREADYM) data_phase_d = 1'b0;

    // Tracks whether the output slave saw the previous beat; lost with the grant.
    seen_d = seen_q;
    if (!grant)      seen_d = 1'b0;
    else if (accept) seen_d = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_valid_q <= 1'b0;
      data_phase_q <= 1'b0;
      seen_q       <= 1'b0;
      haddr_q      <= '0;
      htrans_q     <= '0;
      hwrite_q     <= 1'b0;
      hsize_q      <= '0;
      hburst_q     <= '0;
      hprot_q      <= '0;
      hmastlock_q  <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      data_phase_q <= data_phase_d;
      seen_q       <= seen_d;
      if (load_en) begin
        haddr_q     <= HADDRS;
        htrans_q    <= HTRANSS;
        hwrite_q    <= HWRITES;
        hsize_q     <= HSIZES;
        hburst_q    <= HBURSTS;
        hprot_q     <= HPROTS;
        hmastlock_q <= HMASTLOCKS;
      end
    end
  end

  always_comb begin
    if (hold_valid_q) begin
      HSELM      = 1'b1;
      HADDRM     = haddr_q;
      // A SEQ beat the slave never saw the start of must be restarted as NONSEQ.
      HTRANSM    = (htrans_q == 2'b11 && !seen_q) ? 2'b10 : htrans_q;
      HWRITEM    = hwrite_q;
      HSIZEM     = hsize_q;
      HBURSTM    = hburst_q;
      HPROTM     = hprot_q;
      HMASTLOCKM = hmastlock_q;
    end else begin
      HSELM      = HSELS & ~sel_none;
      HADDRM     = HADDRS;
      HTRANSM    = HTRANSS;
      HWRITEM    = HWRITES;
      HSIZEM     = HSIZES;
      HBURSTM    = HBURSTS;
      HPROTM     = HPROTS;
      HMASTLOCKM = HMASTLOCKS;
    end
  end

  // A locked master keeps its port requested across IDLE cycles.
  assign req_port = hold_valid_q | live_valid | (HSELS & HMASTLOCKS & ~sel_none);

  always_comb begin
    if (hold_valid_q)      HREADYOUTS = 1'b0;
    else if (data_phase_q) HREADYOUTS = HREADYM;
    else                   HREADYOUTS = err_ready;
    HRESPS = data_phase_q ? HRESPM : err_resp;
  end

`ifdef CM0_MTX_IN_ERR_EN
  typedef enum logic [1:0] {StIdle, StErr1, StErr2} err_state_e;

  err_state_e err_state_q;
  logic       err_ready_q, err_resp_q;
  logic       err_trig;

  assign err_trig = HSELS & HREADYS & HTRANSS[1] & sel_none;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_state_q <= StIdle;
      err_ready_q <= 1'b1;
      err_resp_q  <= 1'b0;
    end else begin
      unique case (err_state_q)
        StIdle: begin
          if (err_trig) begin
            err_state_q <= StErr1;
            err_ready_q <= 1'b0;
            err_resp_q  <= 1'b1;
          end
        end
        StErr1: begin
          err_state_q <= StErr2;
          err_ready_q <= 1'b1;
          err_resp_q  <= 1'b1;
        end
        StErr2: begin
          if (err_trig) begin
            err_state_q <= StErr1;
            err_ready_q <= 1'b0;
            err_resp_q  <= 1'b1;
          end else begin
            err_state_q <= StIdle;
            err_ready_q <= 1'b1;
            err_resp_q  <= 1'b0;
          end
        end
        default: begin
          err_state_q <= StIdle;
          err_ready_q <= 1'b1;
          err_resp_q  <= 1'b0;
        end
      endcase
    end
  end

  assign err_ready = err_ready_q;
  assign err_resp  = err_resp_q;
`else
  assign err_ready = 1'b1;
  assign err_resp  = 1'b0;
`endif

endmodule

// File: tb/tb_cm0_mtx_in_hold.sv
// Directed bench for cm0_mtx_in_hold; expectations queued per cycle, checked at the falling edge.
module tb_cm0_mtx_in_hold;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS, HWRITES, HMASTLOCKS, HREADYS, sel_none, grant, HREADYM, HRESPM;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic [2:0]  HSIZES, HBURSTS;
  logic [3:0]  HPROTS;
  logic        HREADYOUTS, HRESPS, req_port, HSELM, HWRITEM, HMASTLOCKM;
  logic [31:0] HADDRM;
  logic [1:0]  HTRANSM;
  logic [2:0]  HSIZEM, HBURSTM;
  logic [3:0]  HPROTM;

  cm0_mtx_in_hold #(.ADDR_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .sel_none(sel_none), .req_port(req_port), .grant(grant), .HREADYM(HREADYM),
    .HRESPM(HRESPM), .HSELM(HSELM), .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM),
    .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTLOCKM(HMASTLOCKM)
  );

  always #5 HCLK = ~HCLK;

  localparam int SigRdy = 0, SigResp = 1, SigReq = 2, SigAddr = 3, SigTrans = 4, SigSel = 5,
                 SigLock = 6;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int sig);
    case (sig)
      SigRdy:   return {31'b0, HREADYOUTS};
      SigResp:  return {31'b0, HRESPS};
      SigReq:   return {31'b0, req_port};
      SigAddr:  return HADDRM;
      SigTrans: return {30'b0, HTRANSM};
      SigSel:   return {31'b0, HSELM};
      default:  return {31'b0, HMASTLOCKM};
    endcase
  endfunction

  task automatic expect_v(input string name, input int sig, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc; e.sig = sig; e.exp = v; e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: pops every expectation due this cycle and compares against the live outputs.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge HCLK);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e   = sb.pop_front();
        act = sample(e.sig);
        n_vec++;
        if (e.cyc != cyc || act !== e.exp) begin
          n_fail++;
          $display("FAIL %s (cycle %0d): got %0h, expected %0h", e.name, e.cyc, act, e.exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic sel, input logic rdy, input logic [1:0] tr,
                       input logic [31:0] addr, input logic gnt, input logic rdym);
    HSELS = sel; HREADYS = rdy; HTRANSS = tr; HADDRS = addr; grant = gnt; HREADYM = rdym;
  endtask

  initial begin
    HRESETn = 1'b0; sel_none = 1'b0; HMASTLOCKS = 1'b0; HRESPM = 1'b0;
    HWRITES = 1'b0; HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'd3;
    drive(1'b0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b1);

    step();
    expect_v("reset_rdy", SigRdy, 1);
    expect_v("reset_resp", SigResp, 0);
    expect_v("reset_req", SigReq, 0);
    expect_v("reset_hselm", SigSel, 0);
    step();
    HRESETn = 1'b1;

    // Pass-through with grant: zero wait, no capture.
    step();
    drive(1'b1, 1'b1, 2'b10, 32'h0000_1000, 1'b1, 1'b1);
    expect_v("pass_addr", SigAddr, 32'h1000);
    expect_v("pass_req", SigReq, 1);
    expect_v("pass_rdy", SigRdy, 1);
    expect_v("pass_hselm", SigSel, 1);
    step();
    drive(1'b0, 1'b1, 2'b00, 32'h0, 1'b1, 1'b1);
    expect_v("pass_dp_rdy", SigRdy, 1);
    expect_v("pass_dp_req", SigReq, 0);

    // Held NONSEQ: three stalled cycles, then granted.
    step();
    drive(1'b1, 1'b1, 2'b10, 32'h0000_2000, 1'b0, 1'b1);
    expect_v("hold_live_addr", SigAddr, 32'h2000);
    expect_v("hold_live_rdy", SigRdy, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      drive(1'b1, 1'b0, 2'b10, 32'hDEAD_0000, (i == 2), 1'b1);
      expect_v("hold_rdy", SigRdy, 0);
      expect_v("hold_addr", SigAddr, 32'h2000);
      expect_v("hold_req", SigReq, 1);
      expect_v("hold_hselm", SigSel, 1);
    end
    step();
    drive(1'b0, 1'b1, 2'b00, 32'h0, 1'b1, 1'b1);
    expect_v("hold_done_rdy", SigRdy, 1);
    expect_v("hold_done_req", SigReq, 0);

    // INCR4 with grant lost before beat 2: held SEQ restarts as NONSEQ.
    step();
    drive(1'b1, 1'b1, 2'b10, 32'h0000_3000, 1'b1, 1'b1);
    expect_v("incr_b1_trans", SigTrans, 2'b10);
    step();
    drive(1'b1, 1'b1, 2'b11, 32'h0000_3004, 1'b0, 1'b1);
    expect_v("incr_b2_live_trans", SigTrans, 2'b11);
    expect_v("incr_b2_rdy", SigRdy, 1);
    step();
    drive(1'b1, 1'b0, 2'b11, 32'h0000_3004, 1'b0, 1'b1);
    expect_v("incr_held_trans", SigTrans, 2'b10);
    expect_v("incr_held_rdy", SigRdy, 0);
    step();
    drive(1'b1, 1'b0, 2'b11, 32'h0000_3004, 1'b1, 1'b1);
    expect_v("incr_regrant_trans", SigTrans, 2'b10);
    expect_v("incr_regrant_addr", SigAddr, 32'h3004);
    step();
    drive(1'b0, 1'b1, 2'b00, 32'h0, 1'b1, 1'b1);
    expect_v("incr_dp_rdy", SigRdy, 1);

    // Output-side wait states propagate to the master.
    step();
    drive(1'b1, 1'b1, 2'b10, 32'h0000_4000, 1'b1, 1'b1);
    step();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
    HRESPM = 1'b1;
    expect_v("wait1_rdy", SigRdy, 0);
    expect_v("wait1_resp", SigResp, 1);
    step();
    HRESPM = 1'b0;
    expect_v("wait2_rdy", SigRdy, 0);
    step();
    HREADYM = 1'b1;
    expect_v("wait3_rdy", SigRdy, 1);
    expect_v("wait3_resp", SigResp, 0);
    step();
    HREADYS = 1'b1;
    HRESPM = 1'b1;
    expect_v("no_dp_resp", SigResp, 0);
    step();
    HRESPM = 1'b0;

    // Unmapped address.
    drive(1'b1, 1'b1, 2'b10, 32'hF000_0000, 1'b0, 1'b1);
    sel_none = 1'b1;
    expect_v("err_req", SigReq, 0);
    expect_v("err_hselm", SigSel, 0);
    expect_v("err_addr_rdy", SigRdy, 1);
    step();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1);
    sel_none = 1'b0;
`ifdef CM0_MTX_IN_ERR_EN
    expect_v("err1_rdy", SigRdy, 0);
    expect_v("err1_resp", SigResp, 1);
    step();
    HREADYS = 1'b1;
    expect_v("err2_rdy", SigRdy, 1);
    expect_v("err2_resp", SigResp, 1);
`else
    expect_v("okay_rdy", SigRdy, 1);
    expect_v("okay_resp", SigResp, 0);
    step();
    HREADYS = 1'b1;
`endif
    step();
    expect_v("err_after_rdy", SigRdy, 1);
    expect_v("err_after_resp", SigResp, 0);

    // Locked IDLE keeps the request up.
    step();
    drive(1'b1, 1'b1, 2'b00, 32'h0, 1'b0, 1'b1);
    HMASTLOCKS = 1'b1;
    expect_v("lock_req", SigReq, 1);
    expect_v("lock_pass", SigLock, 1);
    step();
    HMASTLOCKS = 1'b0;
    expect_v("unlock_req", SigReq, 0);

    // Asynchronous reset while holding.
    step();
    drive(1'b1, 1'b1, 2'b10, 32'h0000_5000, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b0, 2'b10, 32'h0000_5000, 1'b0, 1'b1);
    expect_v("prerst_rdy", SigRdy, 0);
    step();
    HRESETn = 1'b0;
    #1;
    expect_v("rst_hold_rdy", SigRdy, 1);
    expect_v("rst_hold_resp", SigResp, 0);
    expect_v("rst_hold_req", SigReq, 0);
    step();
    HRESETn = 1'b1;
    drive(1'b0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b1);
    expect_v("post_rst_hselm", SigSel, 0);
    expect_v("post_rst_rdy", SigRdy, 1);

    step();
    step();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      n_fail += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
